// File: rtl/gate_sched.sv
// Round-robin scheduler sharing one fare-gate sequencer among N_REQ card readers.
// Latches the winner's balance, runs READ/CHECK/GO, deducts the fare and reports completion.
module gate_sched #(
    parameter int N_REQ    = 4,
    parameter int BAL_W    = 4,
    parameter int FARE     = 4,
    parameter int READ_CYC = 2,
    parameter int GO_CYC   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*BAL_W-1:0] bal,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic                   gate_run,
    output logic [BAL_W-1:0]       gate_balance,
    output logic                   gate_go,
    output logic                   done,
    output logic                   pass,
    output logic                   aborted,
    output logic [BAL_W-1:0]       new_bal
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int CNT_MAX = (READ_CYC > GO_CYC) ? READ_CYC : GO_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_GO,
        S_RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [BAL_W-1:0]   bal_q, bal_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               gate_run_q, gate_run_d;
    logic [BAL_W-1:0]   gate_balance_q, gate_balance_d;
    logic               gate_go_q, gate_go_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               aborted_q, aborted_d;
    logic [BAL_W-1:0]   new_bal_q, new_bal_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [BAL_W-1:0]   pick_bal;

    // Descending scan so the candidate closest after the pointer is written last and wins.
    function automatic logic [IDX_W:0] rr_pick(input logic [IDX_W-1:0] ptr,
                                               input logic [N_REQ-1:0] r);
        logic [IDX_W:0] res;
        int             j;
        res = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            j = (int'(ptr) + i) % N_REQ;
            if (r[j]) res = {1'b1, IDX_W'(j)};
        end
        return res;
    endfunction

    always_comb begin
        {pick_found, pick_idx} = rr_pick(ptr_q, req);
        pick_bal = bal[int'(pick_idx)*BAL_W +: BAL_W];
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ptr_d          = ptr_q;
        win_d          = win_q;
        bal_d          = bal_q;
        grant_d        = grant_q;
        gate_balance_d = gate_balance_q;
        pass_d         = pass_q;
        aborted_d      = aborted_q;
        new_bal_d      = new_bal_q;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    win_d          = pick_idx;
                    bal_d          = pick_bal;
                    grant_d        = N_REQ'(1) << pick_idx;
                    gate_balance_d = pick_bal;
                    cnt_d          = '0;
                    pass_d         = 1'b0;
                    aborted_d      = 1'b0;
                    new_bal_d      = '0;
                    state_d        = S_READ;
                end
            end
            S_READ: begin
                // Withdrawal beats count expiry in the same cycle.
                if (!req[win_q]) begin
                    pass_d    = 1'b0;
                    aborted_d = 1'b1;
                    new_bal_d = bal_q;
                    state_d   = S_RELEASE;
                end else if (cnt_q == CNT_W'(READ_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (bal_q > BAL_W'(FARE)) begin
                    new_bal_d = bal_q - BAL_W'(FARE);
                    pass_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_GO;
                end else begin
                    new_bal_d = bal_q;
                    pass_d    = 1'b0;
                    state_d   = S_RELEASE;
                end
            end
            S_GO: begin
                if (cnt_q == CNT_W'(GO_CYC - 1)) begin
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                ptr_d          = win_q;
                grant_d        = '0;
                gate_balance_d = '0;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d != S_IDLE);
        gate_run_d = (state_d == S_READ);
        gate_go_d  = (state_d == S_GO);
        done_d     = (state_d == S_RELEASE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            ptr_q          <= IDX_W'(N_REQ - 1);
            win_q          <= '0;
            bal_q          <= '0;
            grant_q        <= '0;
            busy_q         <= 1'b0;
            gate_run_q     <= 1'b0;
            gate_balance_q <= '0;
            gate_go_q      <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            aborted_q      <= 1'b0;
            new_bal_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ptr_q          <= ptr_d;
            win_q          <= win_d;
            bal_q          <= bal_d;
            grant_q        <= grant_d;
            busy_q         <= busy_d;
            gate_run_q     <= gate_run_d;
            gate_balance_q <= gate_balance_d;
            gate_go_q      <= gate_go_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            aborted_q      <= aborted_d;
            new_bal_q      <= new_bal_d;
        end
    end

    assign grant        = grant_q;
    assign busy         = busy_q;
    assign gate_run     = gate_run_q;
    assign gate_balance = gate_balance_q;
    assign gate_go      = gate_go_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign aborted      = aborted_q;
    assign new_bal      = new_bal_q;

endmodule

// File: tb/tb_gate_sched.sv
// Self-checking bench for gate_sched: directed scenarios plus randomized transactions
// checked against a timeline model derived from the round-robin and fare rules.
module tb_gate_sched;

    localparam int N_REQ    = 4;
    localparam int BAL_W    = 4;
    localparam int FARE     = 4;
    localparam int READ_CYC = 2;
    localparam int GO_CYC   = 4;
    localparam int MAXC     = 64;
    localparam int VW       = N_REQ + 4 + BAL_W;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*BAL_W-1:0] bal;
    logic [N_REQ-1:0]       grant;
    logic                   busy, gate_run, gate_go, done, pass, aborted;
    logic [BAL_W-1:0]       gate_balance, new_bal;

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m;

    logic [N_REQ-1:0] g_log   [MAXC];
    logic             busy_log[MAXC];
    logic             run_log [MAXC];
    logic             go_log  [MAXC];
    logic             done_log[MAXC];
    logic             pass_log[MAXC];
    logic             ab_log  [MAXC];
    logic [BAL_W-1:0] gb_log  [MAXC];
    logic [BAL_W-1:0] nb_log  [MAXC];

    gate_sched #(
        .N_REQ(N_REQ), .BAL_W(BAL_W), .FARE(FARE), .READ_CYC(READ_CYC), .GO_CYC(GO_CYC)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .bal(bal), .grant(grant), .busy(busy),
        .gate_run(gate_run), .gate_balance(gate_balance), .gate_go(gate_go), .done(done),
        .pass(pass), .aborted(aborted), .new_bal(new_bal)
    );

    always #5 clk = ~clk;

    function automatic int rr_pick(input int ptr, input logic [N_REQ-1:0] r);
        for (int i = 1; i <= N_REQ; i++)
            if (r[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
        return -1;
    endfunction

    function automatic int done_cycle(input bit p, input int abort_d);
        if (abort_d > 0) return abort_d + 1;
        return p ? READ_CYC + 2 + GO_CYC : READ_CYC + 2;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        bal   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        ptr_m = N_REQ - 1;
    endtask

    // Records one output snapshot per cycle; cycle 1 follows the edge that samples the request.
    task automatic capture(input int ncyc, input int drop_rdr, input int drop_d,
                           input bit scramble, input bit stop_on_done, output int used);
        int stop_at;
        stop_at = -1;
        used    = ncyc;
        for (int c = 0; c < MAXC; c++) begin
            g_log[c] = 'x; busy_log[c] = 'x; run_log[c] = 'x; go_log[c] = 'x;
            done_log[c] = 'x; pass_log[c] = 'x; ab_log[c] = 'x; gb_log[c] = 'x; nb_log[c] = 'x;
        end
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            g_log[c] = grant; busy_log[c] = busy; run_log[c] = gate_run; go_log[c] = gate_go;
            done_log[c] = done; pass_log[c] = pass; ab_log[c] = aborted;
            gb_log[c] = gate_balance; nb_log[c] = new_bal;
            if (c == stop_at) begin
                used = c;
                break;
            end
            if (scramble && c == 1) bal = (N_REQ*BAL_W)'($urandom);
            if (c == drop_d) req[drop_rdr] = 1'b0;
            if (stop_on_done && done === 1'b1) begin
                req     = '0;
                stop_at = c + 1;
            end
        end
    endtask

    task automatic test_reset();
        logic [VW+BAL_W+1:0] obs;
        reset = 1'b0;
        req   = '1;
        bal   = '1;
        repeat (3) @(posedge clk);
        #1;
        obs = {grant, busy, gate_run, gate_go, done, pass, aborted, gate_balance, new_bal};
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_held: outputs=%h expected 0", obs);
        end
        req = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        obs = {grant, busy, gate_run, gate_go, done, pass, aborted, gate_balance, new_bal};
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_idle: outputs=%h expected 0", obs);
        end
    endtask

    task automatic test_single();
        int used, dc;
        do_reset();
        bal[0 +: BAL_W] = BAL_W'(9);
        req = 4'b0001;
        capture(20, 0, 0, 1'b0, 1'b1, used);
        dc = done_cycle(1'b1, 0);
        n_checks++;
        if (g_log[1] !== 4'b0001) begin
            n_fail++; $display("[TB] FAIL single_grant: got %b expected 0001", g_log[1]);
        end
        for (int c = 1; c <= READ_CYC + 2; c++) begin
            n_checks++;
            if (run_log[c] !== (c <= READ_CYC)) begin
                n_fail++; $display("[TB] FAIL single_run c%0d: got %b expected %b", c, run_log[c], c <= READ_CYC);
            end
        end
        for (int c = READ_CYC + 1; c <= READ_CYC + GO_CYC + 2; c++) begin
            n_checks++;
            if (go_log[c] !== (c >= READ_CYC + 2 && c <= READ_CYC + GO_CYC + 1)) begin
                n_fail++; $display("[TB] FAIL single_go c%0d: got %b", c, go_log[c]);
            end
        end
        n_checks++;
        if ({done_log[dc-1], done_log[dc], pass_log[dc], nb_log[dc]} !== {1'b0, 1'b1, 1'b1, BAL_W'(9 - FARE)}) begin
            n_fail++;
            $display("[TB] FAIL single_done: done[%0d]=%b done[%0d]=%b pass=%b new_bal=%0d expected 0,1,1,%0d",
                     dc - 1, done_log[dc-1], dc, done_log[dc], pass_log[dc], nb_log[dc], 9 - FARE);
        end
        n_checks++;
        if (busy_log[dc+1] !== 1'b0) begin
            n_fail++; $display("[TB] FAIL single_busy_after: got %b expected 0", busy_log[dc+1]);
        end
    endtask

    task automatic test_deny_boundary();
        int  used, dc;
        logic any_go;
        do_reset();
        bal[0 +: BAL_W] = BAL_W'(FARE);
        req = 4'b0001;
        capture(20, 0, 0, 1'b0, 1'b1, used);
        dc = done_cycle(1'b0, 0);
        any_go = 1'b0;
        for (int c = 1; c <= used; c++) any_go = any_go | go_log[c];
        n_checks++;
        if ({done_log[dc], pass_log[dc], ab_log[dc], nb_log[dc], any_go} !== {1'b1, 1'b0, 1'b0, BAL_W'(FARE), 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL deny_at_fare: done=%b pass=%b aborted=%b new_bal=%0d go_seen=%b expected 1,0,0,%0d,0",
                     done_log[dc], pass_log[dc], ab_log[dc], nb_log[dc], any_go, FARE);
        end
        bal[0 +: BAL_W] = BAL_W'(FARE + 1);
        req = 4'b0001;
        capture(20, 0, 0, 1'b0, 1'b1, used);
        dc = done_cycle(1'b1, 0);
        n_checks++;
        if ({done_log[dc], pass_log[dc], nb_log[dc]} !== {1'b1, 1'b1, BAL_W'(1)}) begin
            n_fail++;
            $display("[TB] FAIL pass_above_fare: done=%b pass=%b new_bal=%0d expected 1,1,1",
                     done_log[dc], pass_log[dc], nb_log[dc]);
        end
    endtask

    task automatic test_round_robin();
        int used, ptr, w;
        int onsets[$];
        do_reset();
        for (int i = 0; i < N_REQ; i++) bal[i*BAL_W +: BAL_W] = BAL_W'(9);
        req = '1;
        capture(60, 0, 0, 1'b0, 1'b0, used);
        for (int c = 1; c <= used; c++)
            if (g_log[c] !== '0 && (c == 1 || g_log[c-1] === '0)) onsets.push_back(c);
        n_checks++;
        if (onsets.size() < 5) begin
            n_fail++; $display("[TB] FAIL rr_grant_count: got %0d expected >=5", onsets.size());
        end else begin
            ptr = N_REQ - 1;
            for (int k = 0; k < 5; k++) begin
                w = rr_pick(ptr, '1);
                ptr = w;
                n_checks++;
                if (g_log[onsets[k]] !== N_REQ'(1) << w) begin
                    n_fail++;
                    $display("[TB] FAIL rr_order k%0d: got %b expected %b", k, g_log[onsets[k]], N_REQ'(1) << w);
                end
                if (k > 0) begin
                    n_checks++;
                    if ({busy_log[onsets[k]-1], done_log[onsets[k]-2]} !== 2'b01) begin
                        n_fail++;
                        $display("[TB] FAIL rr_idle_gap k%0d: busy_before=%b done_before2=%b expected 0,1",
                                 k, busy_log[onsets[k]-1], done_log[onsets[k]-2]);
                    end
                end
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        bal[2*BAL_W +: BAL_W] = BAL_W'(7);
        req = 4'b0100;
        @(posedge clk); #1;
        n_checks++;
        if (grant !== 4'b0100) begin
            n_fail++; $display("[TB] FAIL abort_grant: got %b expected 0100", grant);
        end
        @(posedge clk); #1;
        req = 4'b1001;
        @(posedge clk); #1;
        n_checks++;
        if ({done, aborted, pass, new_bal} !== {1'b1, 1'b1, 1'b0, BAL_W'(7)}) begin
            n_fail++;
            $display("[TB] FAIL abort_done: done=%b aborted=%b pass=%b new_bal=%0d expected 1,1,0,7",
                     done, aborted, pass, new_bal);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({busy, grant} !== {1'b0, 4'b0000}) begin
            n_fail++; $display("[TB] FAIL abort_idle: busy=%b grant=%b expected 0,0000", busy, grant);
        end
        @(posedge clk); #1;
        n_checks++;
        if (grant !== 4'b1000) begin
            n_fail++; $display("[TB] FAIL abort_next_grant: got %b expected 1000", grant);
        end
    endtask

    task automatic test_reset_mid_go();
        logic [VW+BAL_W+1:0] obs;
        do_reset();
        bal[0 +: BAL_W] = BAL_W'(9);
        req = 4'b0001;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (gate_go !== 1'b1) begin
            n_fail++; $display("[TB] FAIL midgo_go: got %b expected 1", gate_go);
        end
        #2;
        reset = 1'b0;
        #1;
        obs = {grant, busy, gate_run, gate_go, done, pass, aborted, gate_balance, new_bal};
        n_checks++;
        if (obs !== '0) begin
            n_fail++; $display("[TB] FAIL midgo_async_clear: outputs=%h expected 0", obs);
        end
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b0010;
        @(posedge clk); #1;
        n_checks++;
        if ({grant, busy, done} !== {4'b0010, 1'b1, 1'b0}) begin
            n_fail++; $display("[TB] FAIL midgo_regrant: grant=%b busy=%b done=%b expected 0010,1,0", grant, busy, done);
        end
    endtask

    task automatic test_max_balance();
        int used, dc;
        do_reset();
        bal[0 +: BAL_W] = '1;
        req = 4'b0001;
        capture(20, 0, 0, 1'b0, 1'b1, used);
        dc = done_cycle(1'b1, 0);
        n_checks++;
        if ({done_log[dc], pass_log[dc], nb_log[dc]} !== {1'b1, 1'b1, BAL_W'((2**BAL_W - 1) - FARE)}) begin
            n_fail++;
            $display("[TB] FAIL max_balance: done=%b pass=%b new_bal=%0d expected 1,1,%0d",
                     done_log[dc], pass_log[dc], nb_log[dc], (2**BAL_W - 1) - FARE);
        end
    endtask

    task automatic test_random();
        int used, w, dc, ab, balw, rd_end, exp_nb;
        bit p, exp_go;
        logic [N_REQ-1:0] r, oh;
        logic [VW-1:0] obs, expv;
        do_reset();
        for (int t = 0; t < 25; t++) begin
            r    = N_REQ'($urandom_range(1, 2**N_REQ - 1));
            bal  = (N_REQ*BAL_W)'($urandom);
            w    = rr_pick(ptr_m, r);
            balw = int'(bal[w*BAL_W +: BAL_W]);
            p    = balw > FARE;
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, READ_CYC)) : 0;
            dc   = done_cycle(p, ab);
            rd_end = (ab > 0) ? ab : READ_CYC;
            oh   = N_REQ'(1) << w;
            req  = r;
            capture(24, w, ab, 1'b1, 1'b1, used);
            for (int c = 1; c <= dc + 1; c++) begin
                exp_go = (ab == 0) && p && c >= READ_CYC + 2 && c <= READ_CYC + 1 + GO_CYC;
                expv = {(c <= dc) ? oh : N_REQ'(0), c <= dc, c <= rd_end, exp_go, c == dc,
                        (c <= dc) ? BAL_W'(balw) : BAL_W'(0)};
                obs  = {g_log[c], busy_log[c], run_log[c], go_log[c], done_log[c], gb_log[c]};
                n_checks++;
                if (obs !== expv) begin
                    n_fail++;
                    $display("[TB] FAIL rand_t%0d_c%0d grant/busy/run/go/done/gbal: got %h expected %h", t, c, obs, expv);
                end
            end
            exp_nb = (ab == 0 && p) ? balw - FARE : balw;
            n_checks++;
            if ({pass_log[dc], ab_log[dc], nb_log[dc]} !== {(ab == 0) && p, ab > 0, BAL_W'(exp_nb)}) begin
                n_fail++;
                $display("[TB] FAIL rand_t%0d_report: pass=%b aborted=%b new_bal=%0d expected %b,%b,%0d",
                         t, pass_log[dc], ab_log[dc], nb_log[dc], (ab == 0) && p, ab > 0, exp_nb);
            end
            ptr_m = w;
        end
    endtask

    initial begin
        reset = 1'b0;
        req   = '0;
        bal   = '0;
        test_reset();
        test_single();
        test_deny_boundary();
        test_round_robin();
        test_abort();
        test_reset_mid_go();
        test_max_balance();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
